rob_alloc_retire: RTL
=====================

// Module: rob_alloc_retire
// PURPOSE
//  Reorder buffer allocate/retire control. Issue side: hands ROB IDs (rob_is_ptr, rob_is_ptr_p1) and rob_full to the front-end rename stage.
//  Completion side: accepts execution completions. Retire side: drives the in-order retire bus (rd_ret/val_ret/branch_ret/robid_ret)
//  and the mispredict flush (branch_clear, mispredict_tag) consumed by the rename table and branch-copy registers.
// PARAMETERS
//  ISSUE_WIDTH    2   instructions allocated per cycle
//  RETIRE_WIDTH   2   max entries retired per cycle
//  CMPL_WIDTH     2   completion ports
//  ROB_SIZE       16  entries, power of two
//  ROB_SIZE_CLOG  4   log2(ROB_SIZE)
//  SRC_LEN        5   architectural register index width
// PORTS
//  clk              in   1                          clock
//  rst              in   1                          synchronous, active-high reset
//  instr_val_is     in   ISSUE_WIDTH                slot valid
//  rd_is            in   ISSUE_WIDTH*SRC_LEN        destination register per slot
//  nowr_is          in   ISSUE_WIDTH                slot writes no rd (branch/store)
//  br_is            in   ISSUE_WIDTH                slot is a conditional branch
//  cmpl_val         in   CMPL_WIDTH                 completion valid
//  cmpl_robid       in   CMPL_WIDTH*ROB_SIZE_CLOG   completing entry
//  cmpl_mispred     in   CMPL_WIDTH                 branch resolved mispredicted
//  rob_is_ptr       out  ROB_SIZE_CLOG              ID for first valid slot (= tail)
//  rob_is_ptr_p1    out  ROB_SIZE_CLOG              tail+1 (mod ROB_SIZE)
//  rob_full         out  1                          fewer than ISSUE_WIDTH free entries
//  rob_empty        out  1                          no occupied entries
//  rd_ret           out  RETIRE_WIDTH*SRC_LEN       retiring rd
//  val_ret          out  RETIRE_WIDTH               retire lane valid
//  branch_ret       out  RETIRE_WIDTH               lane retires with no rd write
//  robid_ret        out  RETIRE_WIDTH*ROB_SIZE_CLOG retiring entry ID
//  branch_clear     out  1                          one-cycle flush pulse
//  mispredict_tag   out  ROB_SIZE_CLOG              ID of mispredicted branch
// BEHAVIOUR
//  - Circular buffer: head, tail, count (ROB_SIZE_CLOG+1 bits); all pointer arithmetic mod ROB_SIZE.
//    Entry fields: busy, done, mispred, nowr, br, rd.
//  - Reset: all entries not busy; head=tail=count=0.
//    Registered outputs: val_ret=0, branch_ret=0, rd_ret=0, robid_ret=0, branch_clear=0, mispredict_tag=0.
//    Combinational outputs: rob_full=0, rob_empty=1.
//  - Reset mid-operation discards all entries; no retire is emitted for them.
//  - rob_full = count > ROB_SIZE-ISSUE_WIDTH; rob_empty = (count==0).
//  - Allocate, on the clock edge, when ~rob_full:
//    - Valid slots take consecutive IDs from tail in slot order; invalid slots are skipped
//      (only slot1 valid -> it gets tail).
//    - tail += popcount(instr_val_is).
//    - When rob_full, allocation is dropped; the issuer holds.
//  - Complete, on the clock edge: sets done (and mispred) for busy entries; completion to a non-busy entry is ignored.
//    - A completed entry is retire-eligible the next cycle; there is no same-cycle bypass.
//  - Retire: lanes 0..RETIRE_WIDTH-1 examine head+k in order.
//    - Lane k retires iff all lanes <k retire, the entry is busy&done, and no earlier lane this cycle is mispredicted.
//    - Retire bus is registered: a decision in cycle N appears at outputs in N+1 and head advances at edge N.
//    - branch_ret = nowr of the entry; rd_ret is 0 for nowr entries.
//  - Mispredict: when a retiring lane's entry has mispred, later lanes do not retire that cycle.
//    - That entry retires normally on the bus; branch_clear=1 and mispredict_tag=its ID are registered alongside it.
//    - All younger entries are cleared; tail=head=ID+1; count=0.
//    - Allocation in that cycle is dropped (flush has priority).
//  - Simultaneous alloc+retire (no flush): count_next = count + allocated - retired.
//    The full check uses the current count only.
//  - Wrap-around: IDs wrap ROB_SIZE-1 -> 0. rob_is_ptr_p1 wraps likewise.
// TESTING
//  1 rst, then 2 valid slots rd=3,4 -> IDs 0,1, tail=2.
//    Complete 1 then 0 -> retire bus shows rd 3,4 / IDs 0,1 together one cycle after the second completion.
//  2 Fill to count=15 -> rob_full=1. Allocation attempt ignored (tail unchanged).
//    Retire 2 -> rob_full deasserts when count<=14.
//  3 Allocate across the wrap boundary with tail=15 -> IDs 15,0; rob_is_ptr_p1=0.
//    Entries retire in order 15 then 0.
//  4 Branch at ID 5 completes mispred, ID 6 done, IDs 7-9 busy -> retire cycle: lane0 ID5 branch_ret=1, lane1 invalid;
//    branch_clear=1, tag=5; next cycle count=0, tail=6, rob_empty=1.
//  5 Store (nowr_is=1, rd field 9) retires -> branch_ret=1, rd_ret=0.
//    A completion to a freed ID is ignored (no state change).
//  6 Assert rst with 6 busy entries and a completion in flight -> next cycle all outputs at reset values, no val_ret pulse.

Source files
------------

// File: rtl/rob_alloc_retire.sv
// Reorder buffer allocate/complete/retire control with in-order, registered retire bus and mispredict flush.
// Retire decisions made in cycle N appear on the bus in N+1; allocation is dropped while rob_full or during a flush.
module rob_alloc_retire #(
  parameter int ISSUE_WIDTH   = 2,
  parameter int RETIRE_WIDTH  = 2,
  parameter int CMPL_WIDTH    = 2,
  parameter int ROB_SIZE      = 16,
  parameter int ROB_SIZE_CLOG = 4,
  parameter int SRC_LEN       = 5
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ISSUE_WIDTH-1:0]                 instr_val_is,
  input  logic [ISSUE_WIDTH*SRC_LEN-1:0]         rd_is,
  input  logic [ISSUE_WIDTH-1:0]                 nowr_is,
  input  logic [ISSUE_WIDTH-1:0]                 br_is,
  input  logic [CMPL_WIDTH-1:0]                  cmpl_val,
  input  logic [CMPL_WIDTH*ROB_SIZE_CLOG-1:0]    cmpl_robid,
  input  logic [CMPL_WIDTH-1:0]                  cmpl_mispred,
  output logic [ROB_SIZE_CLOG-1:0]               rob_is_ptr,
  output logic [ROB_SIZE_CLOG-1:0]               rob_is_ptr_p1,
  output logic                                   rob_full,
  output logic                                   rob_empty,
  output logic [RETIRE_WIDTH*SRC_LEN-1:0]        rd_ret,
  output logic [RETIRE_WIDTH-1:0]                val_ret,
  output logic [RETIRE_WIDTH-1:0]                branch_ret,
  output logic [RETIRE_WIDTH*ROB_SIZE_CLOG-1:0]  robid_ret,
  output logic                                   branch_clear,
  output logic [ROB_SIZE_CLOG-1:0]               mispredict_tag
);
  localparam int W = ROB_SIZE_CLOG;

  logic [ROB_SIZE-1:0] busy, done, mispred, nowr, br;
  logic [SRC_LEN-1:0]  rd [ROB_SIZE];
  logic [W-1:0]        head, tail;
  logic [W:0]          count;

  logic [RETIRE_WIDTH-1:0] ret_go;
  logic [W-1:0]            ret_id [RETIRE_WIDTH];
  logic [W:0]              n_ret;
  logic                    chain;
  logic                    flush;
  logic [W-1:0]            flush_id;
  logic [W-1:0]            alloc_id [ISSUE_WIDTH];
  logic [W:0]              n_alloc;
  logic                    alloc_en;

  assign rob_is_ptr    = tail;
  assign rob_is_ptr_p1 = tail + 1'b1;
  assign rob_full      = count > (W+1)'(ROB_SIZE - ISSUE_WIDTH);
  assign rob_empty     = (count == '0);
  assign alloc_en      = ~rob_full & ~flush;

  // A mispredicted entry still retires, but stops every younger lane.
  always_comb begin
    ret_go   = '0;
    n_ret    = '0;
    flush    = 1'b0;
    flush_id = '0;
    chain    = 1'b1;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      ret_id[k] = head + W'(k);
      ret_go[k] = chain & busy[ret_id[k]] & done[ret_id[k]];
      if (ret_go[k] & mispred[ret_id[k]]) begin
        flush    = 1'b1;
        flush_id = ret_id[k];
      end
      chain = ret_go[k] & ~mispred[ret_id[k]];
      n_ret = n_ret + (W+1)'(ret_go[k]);
    end
  end

  always_comb begin
    n_alloc = '0;
    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      alloc_id[s] = tail + n_alloc[W-1:0];
      n_alloc     = n_alloc + (W+1)'(instr_val_is[s]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy           <= '0;
      done           <= '0;
      mispred        <= '0;
      nowr           <= '0;
      br             <= '0;
      for (int i = 0; i < ROB_SIZE; i++) rd[i] <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      val_ret        <= '0;
      branch_ret     <= '0;
      rd_ret         <= '0;
      robid_ret      <= '0;
      branch_clear   <= 1'b0;
      mispredict_tag <= '0;
    end else begin
      // Completions to free entries are ignored; mispredict only sticks on branches.
      for (int c = 0; c < CMPL_WIDTH; c++) begin
        if (cmpl_val[c] && busy[cmpl_robid[c*W +: W]]) begin
          done[cmpl_robid[c*W +: W]]    <= 1'b1;
          mispred[cmpl_robid[c*W +: W]] <= cmpl_mispred[c] & br[cmpl_robid[c*W +: W]];
        end
      end
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
        if (ret_go[k]) busy[ret_id[k]] <= 1'b0;
        val_ret[k]              <= ret_go[k];
        branch_ret[k]           <= ret_go[k] & nowr[ret_id[k]];
        rd_ret[k*SRC_LEN +: SRC_LEN] <= (ret_go[k] && !nowr[ret_id[k]]) ? rd[ret_id[k]] : '0;
        robid_ret[k*W +: W]     <= ret_go[k] ? ret_id[k] : '0;
      end
      branch_clear   <= flush;
      mispredict_tag <= flush ? flush_id : '0;
      if (flush) begin
        busy  <= '0;
        head  <= flush_id + 1'b1;
        tail  <= flush_id + 1'b1;
        count <= '0;
      end else begin
        if (alloc_en) begin
          for (int s = 0; s < ISSUE_WIDTH; s++) begin
            if (instr_val_is[s]) begin
              busy[alloc_id[s]]    <= 1'b1;
              done[alloc_id[s]]    <= 1'b0;
              mispred[alloc_id[s]] <= 1'b0;
              nowr[alloc_id[s]]    <= nowr_is[s];
              br[alloc_id[s]]      <= br_is[s];
              rd[alloc_id[s]]      <= rd_is[s*SRC_LEN +: SRC_LEN];
            end
          end
        end
        head  <= head + n_ret[W-1:0];
        tail  <= tail + (alloc_en ? n_alloc[W-1:0] : '0);
        count <= count + (alloc_en ? n_alloc : '0) - n_ret;
      end
    end
  end
endmodule
